requant_pack_stage: RTL and testbench
=====================================

Name: requant_pack_stage

Overview:
- Downstream neighbour of the systolic-array TPU and its 128-bit C global buffer.
- Consumes one C row per beat: 4 signed int32 accumulators, lane0 at [127:96].
- Requantizes each lane with the TFLite fixed-point path: SRDHM multiply, rounding divide by power of two, output-offset add, activation clamp.
- Packs the four int8 results into one 32-bit word for the CPU to read back.

Parameters:
- LANES, 4, accumulators per beat; fixed to match ARRAY_SIZE.
- ACC_W, 32, accumulator and multiplier width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- cfg_we  in  1  load config registers this cycle.
- cfg_multiplier  in  32  signed quantized multiplier.
- cfg_shift  in  5  right shift, 0..31.
- cfg_out_offset  in  32  signed output zero-point.
- cfg_act_min  in  8  signed clamp low.
- cfg_act_max  in  8  signed clamp high.
- in_valid  in  1  C row valid.
- in_ready  out  1  stage accepts a row.
- in_data  in  128  4 x int32, lane0 in the MSBs.
- bias_data  in  128  per-lane int32 bias (REQUANT_BIAS_EN only).
- out_valid  out  1  packed word valid.
- out_ready  in  1  consumer accepts.
- out_data  out  32  4 x int8, lane0 at [31:24].
- busy  out  1  any pipeline stage holds valid data.

Behaviour:
- Reset: all stage valids 0; out_valid=0; out_data=0; busy=0; in_ready=1 after reset.
- Reset config values: multiplier=0x40000000, shift=0, offset=0, act_min=-128, act_max=127.
- Reset asserted mid-operation discards all in-flight beats; no output is produced for them.
- Config: cfg_we captures all cfg_* fields when busy=0. cfg_we while busy=1 is ignored, with no partial update.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en (combinational).
- All stages advance together on en. A beat is accepted when in_valid && in_ready.
- Bubbles are not collapsed. Ordering is strictly FIFO.
- S1: register the 64-bit signed product acc*multiplier per lane, plus an overflow flag. overflow = (acc==0x80000000 && multiplier==0x80000000).
- S2 (SRDHM): nudge = product>=0 ? 2^30 : 1-2^30.
- S2: result = (product+nudge)/2^31, truncating toward zero.
- S2: if overflow, result = 0x7FFFFFFF.
- S3 (RDBPOT): mask = (1<<shift)-1; rem = x & mask; thr = (mask>>1) + (x<0).
- S3: y = (x>>>shift) + (rem>thr). shift=0 is a pass-through.
- S4: z = y + out_offset, 32-bit wrap.
- S4: clamp to [act_min, act_max] sign-extended; take the low 8 bits; pack into the out_data register; set out_valid.
- Latency: accept to out_valid is 4 cycles without stall, 5 with REQUANT_BIAS_EN. Throughput is 1 beat/cycle when out_ready=1.
- out_data and out_valid hold stable while out_valid && !out_ready.
- Simultaneous accept and emit in one cycle is legal and loses nothing.
- act_min > act_max is not checked; the result equals act_max (min applied last).

Optional Feature:
- Macro REQUANT_BIAS_EN.
- Defined: bias_data port exists. An extra S0 stage registers acc+bias per lane (32-bit wrap) before S1. Latency is 5.
- Undefined: port absent; accumulators feed S1 directly; latency is 4.

Decomposition:
- Package requant_pkg:
  - lane width constants (ACC_W, OUT_W=8).
  - SRDHM nudge constants 0x40000000 and 0xC0000001.
  - INT32_MIN/INT32_MAX.
  - lane slice macros for lane i of 128/32-bit buses.
- Sub-module requant_lane: one lane's S1–S4 datapath, instantiated LANES times.
- The top holds config registers, valid chain, en, and pack logic.

Test Plan:
- Basic: cfg mult=0x40000000, shift=1, offset=-128, min=-128, max=127; in_data={100,101,-101,0x80000000} -> after 4 cycles out_data=0x999A8080.
- Overflow: mult=0x80000000, shift=31, offset=0; in_data={0x80000000,0,0,0} -> out_data=0x01000000.
- Clamp: mult=0x7FFFFFFF, shift=0, offset=0, min=-10, max=20; in_data={1000,-1000,5,0} -> out_data=0x14F60500.
- Backpressure: stream 8 rows with out_ready low 3 cycles mid-stream -> in_ready drops; all 8 words emerge in order with no duplicates or loss.
- Config guard: cfg_we with new offset while busy=1 -> ignored, and in-flight and subsequent results use the old offset; retry with busy=0 -> applied.
- Reset mid-stream: assert reset with 3 beats in flight -> out_valid=0, busy=0 next cycle; no stale word emitted afterwards.

Source files
------------

// File: rtl/requant_pkg.sv
// requant_pkg: lane widths, SRDHM constants, config record and lane-slice macros for requant_pack_stage.
// Latency: none (declarations only).
// Backpressure: not applicable.
`ifndef REQUANT_PKG_SV
`define REQUANT_PKG_SV

// Lane i of the accumulator bus / packed output word; lane 0 sits in the MSBs.
`define REQ_ACC_LANE(bus, i) bus[(LANES-(i))*ACC_W-1 -: ACC_W]
`define REQ_OUT_LANE(bus, i) bus[(LANES-(i))*OUT_W-1 -: OUT_W]

package requant_pkg;

  localparam int LANES  = 4;
  localparam int ACC_W  = 32;
  localparam int OUT_W  = 8;
  localparam int PROD_W = 2 * ACC_W;

  localparam logic [ACC_W-1:0] NUDGE_POS = 32'h4000_0000;
  localparam logic [ACC_W-1:0] NUDGE_NEG = 32'hC000_0001;
  localparam logic [ACC_W-1:0] INT32_MIN = 32'h8000_0000;
  localparam logic [ACC_W-1:0] INT32_MAX = 32'h7FFF_FFFF;

  typedef struct packed {
    logic [ACC_W-1:0] multiplier;
    logic [4:0]       shift;
    logic [ACC_W-1:0] out_offset;
    logic [OUT_W-1:0] act_min;
    logic [OUT_W-1:0] act_max;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{
    multiplier: 32'h4000_0000,
    shift:      5'd0,
    out_offset: 32'h0000_0000,
    act_min:    8'h80,
    act_max:    8'h7F
  };

endpackage

`endif

// File: rtl/requant_lane.sv
// requant_lane: one lane of product -> SRDHM -> rounding shift -> offset/clamp.
// Latency: 3 register stages; offset and clamp feed the parent's output register combinationally.
// Backpressure: all stages hold while en is low.
module requant_lane
  import requant_pkg::*;
(
  input  logic             clk,
  input  logic             en,
  input  logic [ACC_W-1:0] acc,
  input  cfg_t             cfg,
  output logic [OUT_W-1:0] q
);

  logic signed [PROD_W-1:0] acc_ext, mul_ext, s1_prod, nudge, sum, rnd;
  logic                     s1_ovf;
  logic signed [ACC_W-1:0]  s2_x, s3_y, sh, y, z, lo, hi, lo_clamped, r;
  logic        [ACC_W-1:0]  one, mask, rem, thr;
  logic                     round_up;
  logic                     lane_unused;

  assign acc_ext = {{ACC_W{acc[ACC_W-1]}}, acc};
  assign mul_ext = {{ACC_W{cfg.multiplier[ACC_W-1]}}, cfg.multiplier};

  // SRDHM: nudge toward nearest, then divide by 2^31 truncating toward zero.
  assign nudge = s1_prod[PROD_W-1] ? {{ACC_W{1'b1}}, NUDGE_NEG} : {{ACC_W{1'b0}}, NUDGE_POS};
  assign sum   = s1_prod + nudge;
  assign rnd   = sum[PROD_W-1] ? sum + {{ACC_W{1'b0}}, INT32_MAX} : sum;

  // Rounding divide by power of two; sh is kept separate so the shift stays arithmetic.
  assign one      = {{(ACC_W-1){1'b0}}, 1'b1};
  assign mask     = (one << cfg.shift) - one;
  assign rem      = s2_x & mask;
  assign thr      = (mask >> 1) + {{(ACC_W-1){1'b0}}, s2_x[ACC_W-1]};
  assign round_up = rem > thr;
  assign sh       = s2_x >>> cfg.shift;
  assign y        = sh + {{(ACC_W-1){1'b0}}, round_up};

  // Offset then clamp; the upper bound is applied last so an inverted range yields act_max.
  assign z          = s3_y + cfg.out_offset;
  assign lo         = {{(ACC_W-OUT_W){cfg.act_min[OUT_W-1]}}, cfg.act_min};
  assign hi         = {{(ACC_W-OUT_W){cfg.act_max[OUT_W-1]}}, cfg.act_max};
  assign lo_clamped = (z < lo) ? lo : z;
  assign r          = (lo_clamped > hi) ? hi : lo_clamped;
  assign q          = r[OUT_W-1:0];

  assign lane_unused = ^{rnd[PROD_W-1], rnd[ACC_W-2:0], r[ACC_W-1:OUT_W]};

  always_ff @(posedge clk) begin
    if (en) begin
      s1_prod <= acc_ext * mul_ext;
      s1_ovf  <= (acc == INT32_MIN) && (cfg.multiplier == INT32_MIN);
      s2_x    <= s1_ovf ? INT32_MAX : rnd[PROD_W-2:ACC_W-1];
      s3_y    <= y;
    end
  end

endmodule

// File: rtl/requant_pack_stage.sv
// requant_pack_stage: requantize 4 int32 accumulators per beat to int8 and pack them into one 32-bit word.
// Latency: 4 cycles accept-to-out_valid; 5 with REQUANT_BIAS_EN (adds bias_data and a per-lane bias stage).
// Backpressure: every stage freezes while out_valid && !out_ready; in_ready follows combinationally.
module requant_pack_stage
  import requant_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic [ACC_W-1:0]       cfg_multiplier,
  input  logic [4:0]             cfg_shift,
  input  logic [ACC_W-1:0]       cfg_out_offset,
  input  logic [OUT_W-1:0]       cfg_act_min,
  input  logic [OUT_W-1:0]       cfg_act_max,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*ACC_W-1:0] in_data,
`ifdef REQUANT_BIAS_EN
  input  logic [LANES*ACC_W-1:0] bias_data,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic                   busy
);

`ifdef REQUANT_BIAS_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 3;
`endif

  logic                   en, accept, cfg_load;
  logic [DEPTH-1:0]       vld;
  cfg_t                   cfg_q, cfg_in, cfg_live;
  logic [LANES*ACC_W-1:0] lane_acc;
  wire  [LANES*OUT_W-1:0] lane_q;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;
  assign busy     = (|vld) || out_valid;
  assign cfg_load = cfg_we && !busy;

  assign cfg_in = '{
    multiplier: cfg_multiplier,
    shift:      cfg_shift,
    out_offset: cfg_out_offset,
    act_min:    cfg_act_min,
    act_max:    cfg_act_max
  };

  // A beat accepted in the same cycle as a config load must see the new values in its first stage.
  assign cfg_live = cfg_load ? cfg_in : cfg_q;

`ifdef REQUANT_BIAS_EN
  logic [LANES*ACC_W-1:0] s0_acc;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < LANES; i++) begin
        `REQ_ACC_LANE(s0_acc, i) <= `REQ_ACC_LANE(in_data, i) + `REQ_ACC_LANE(bias_data, i);
      end
    end
  end

  assign lane_acc = s0_acc;
`else
  assign lane_acc = in_data;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    requant_lane u_lane (
      .clk (clk),
      .en  (en),
      .acc (`REQ_ACC_LANE(lane_acc, g)),
      .cfg (cfg_live),
      .q   (`REQ_OUT_LANE(lane_q, g))
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      cfg_q     <= CFG_RESET;
    end else begin
      if (cfg_load) cfg_q <= cfg_in;
      if (en) begin
        vld       <= {vld[DEPTH-2:0], accept};
        out_valid <= vld[DEPTH-1];
        if (vld[DEPTH-1]) out_data <= lane_q;
      end
    end
  end

endmodule

// File: tb/tb_requant_pack_stage.sv
// Directed bench for requant_pack_stage: hand-computed requantization vectors, stall, config guard, reset.
module tb_requant_pack_stage;

`ifdef REQUANT_BIAS_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic         clk;
  logic         reset;
  logic         cfg_we;
  logic [31:0]  cfg_multiplier;
  logic [4:0]   cfg_shift;
  logic [31:0]  cfg_out_offset;
  logic [7:0]   cfg_act_min;
  logic [7:0]   cfg_act_max;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
`ifdef REQUANT_BIAS_EN
  logic [127:0] bias_data;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  requant_pack_stage dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_we         (cfg_we),
    .cfg_multiplier (cfg_multiplier),
    .cfg_shift      (cfg_shift),
    .cfg_out_offset (cfg_out_offset),
    .cfg_act_min    (cfg_act_min),
    .cfg_act_max    (cfg_act_max),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
`ifdef REQUANT_BIAS_EN
    .bias_data      (bias_data),
`endif
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row r carries lane values v = 16+4r+l as acc = 2v; with multiplier 2^30 and shift 0 each lane yields v.
  function automatic logic [127:0] row_data(input int r);
    logic [127:0] d;
    d = '0;
    for (int l = 0; l < 4; l++) d[127-32*l -: 32] = 32'(2 * (16 + 4 * r + l));
    return d;
  endfunction

  function automatic logic [31:0] row_exp(input int r);
    logic [31:0] e;
    e = '0;
    for (int l = 0; l < 4; l++) e[31-8*l -: 8] = 8'(16 + 4 * r + l);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [31:0] m, input logic [4:0] s, input logic [31:0] o,
                           input logic [7:0] lo, input logic [7:0] hi);
    cfg_multiplier = m;
    cfg_shift      = s;
    cfg_out_offset = o;
    cfg_act_min    = lo;
    cfg_act_max    = hi;
    cfg_we         = 1'b1;
    tick();
    cfg_we         = 1'b0;
  endtask

  task automatic wait_out(input logic [31:0] exp, input string name);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL %s out_valid timeout got %b want 1", name, out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== exp) $display("FAIL %s out_data got %h want %h", name, out_data, exp);
    else pass_cnt++;
    tick();
  endtask

  task automatic run_one(input logic [127:0] data, input logic [31:0] exp, input string name);
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = data;
    tick();
    in_valid  = 1'b0;
    n = 1;
    while (!out_valid && n < LAT + 10) begin
      tick();
      n++;
    end
    total_cnt++;
    if (n !== LAT) $display("FAIL %s latency got %0d want %0d", name, n, LAT);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== exp) $display("FAIL %s out_data got %h want %h", name, out_data, exp);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    reset     = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++;
    if (out_data !== 32'h0) $display("FAIL reset out_data got %h want 00000000", out_data); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset busy got %b want 0", busy); else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset in_ready got %b want 1", in_ready); else pass_cnt++;
    // Default config: multiplier 2^30, shift 0, offset 0, clamp [-128,127].
    run_one({32'd100, 32'hFFFF_FF9B, 32'd300, 32'hFFFF_FED4}, 32'h32CE_7F80, "reset_cfg");
  endtask

  task automatic test_basic();
    cfg_write(32'h4000_0000, 5'd1, 32'hFFFF_FF80, 8'h80, 8'h7F);
    run_one({32'd100, 32'd101, 32'hFFFF_FF9B, 32'h8000_0000}, 32'h999A_8080, "basic");
  endtask

  task automatic test_overflow();
    cfg_write(32'h8000_0000, 5'd31, 32'h0, 8'h80, 8'h7F);
    run_one({32'h8000_0000, 32'd0, 32'd0, 32'd0}, 32'h0100_0000, "overflow");
  endtask

  task automatic test_clamp();
    cfg_write(32'h7FFF_FFFF, 5'd0, 32'h0, 8'hF6, 8'h14);
    run_one({32'd1000, 32'hFFFF_FC18, 32'd5, 32'd0}, 32'h14F6_0500, "clamp");
    // Inverted range: every lane must come out as act_max (-10).
    cfg_write(32'h7FFF_FFFF, 5'd0, 32'h0, 8'h0A, 8'hF6);
    run_one({32'd0, 32'h7FFF_FFFF, 32'hFFFF_FC18, 32'd5}, 32'hF6F6_F6F6, "inverted_clamp");
  endtask

  task automatic test_backpressure();
    int          sent;
    int          got;
    logic        saw_stall;
    logic        holding;
    logic [31:0] held;
    cfg_write(32'h4000_0000, 5'd0, 32'h0, 8'h80, 8'h7F);
    sent = 0;
    got = 0;
    saw_stall = 1'b0;
    holding = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      out_ready = !(cyc >= 5 && cyc < 8);
      in_valid  = (sent < 8);
      in_data   = row_data(sent);
      #1;
      if (!in_ready) saw_stall = 1'b1;
      if (holding) begin
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== held)
          $display("FAIL bp_hold valid %b data %h want 1 %h", out_valid, out_data, held);
        else pass_cnt++;
        holding = 1'b0;
      end
      if (out_valid && !out_ready) begin
        holding = 1'b1;
        held    = out_data;
      end
      if (out_valid && out_ready) begin
        total_cnt++;
        if (out_data !== row_exp(got)) $display("FAIL bp_word%0d got %h want %h", got, out_data, row_exp(got));
        else pass_cnt++;
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total_cnt++;
    if (got !== 8) $display("FAIL bp_count got %0d want 8", got); else pass_cnt++;
    total_cnt++;
    if (saw_stall !== 1'b1) $display("FAIL bp_in_ready_drop got %b want 1", saw_stall); else pass_cnt++;
    repeat (3) tick();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL bp_no_extra out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL bp_idle busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_config_guard();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = {32'd20, 32'd40, 32'd60, 32'd80};
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL guard_busy got %b want 1", busy); else pass_cnt++;
    cfg_write(32'h4000_0000, 5'd0, 32'd50, 8'h80, 8'h7F);
    wait_out(32'h0A14_1E28, "guard_inflight");
    run_one({32'd22, 32'd42, 32'd62, 32'd82}, 32'h0B15_1F29, "guard_after");
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL guard_idle busy got %b want 0", busy); else pass_cnt++;
    cfg_write(32'h4000_0000, 5'd0, 32'd50, 8'h80, 8'h7F);
    run_one({32'd20, 32'd40, 32'd60, 32'd80}, 32'h3C46_505A, "guard_applied");
  endtask

  task automatic test_reset_midstream();
    logic seen;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = row_data(i);
      tick();
    end
    in_valid = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL mid_busy_before got %b want 1", busy); else pass_cnt++;
    reset = 1'b1;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL mid_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy); else pass_cnt++;
    reset = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL mid_stale got %b want 0", seen); else pass_cnt++;
    // Reset also restores the default config.
    run_one({32'h8000_0000, 32'd2, 32'hFFFF_FFFE, 32'd0}, 32'h8001_FF00, "mid_reset_cfg");
  endtask

  initial begin
    reset          = 1'b1;
    cfg_we         = 1'b0;
    cfg_multiplier = '0;
    cfg_shift      = '0;
    cfg_out_offset = '0;
    cfg_act_min    = '0;
    cfg_act_max    = '0;
    in_valid       = 1'b0;
    in_data        = '0;
    out_ready      = 1'b0;
`ifdef REQUANT_BIAS_EN
    bias_data      = '0;
`endif
    test_reset();
    test_basic();
    test_overflow();
    test_clamp();
    test_backpressure();
    test_config_guard();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
